// File: rtl/car_sensor_pkg.sv
// Shared sensor-line encodings and crossing descriptors for the parking-lot
// sensor emulator and the detector that consumes its lines.
package car_sensor_pkg;

    localparam logic [1:0] SENS_NONE = 2'b00;
    localparam logic [1:0] SENS_A    = 2'b10;
    localparam logic [1:0] SENS_AB   = 2'b11;
    localparam logic [1:0] SENS_B    = 2'b01;

    typedef enum logic { DIR_ENTER, DIR_EXIT } dir_t;
    typedef enum logic { KIND_CAR, KIND_PED } kind_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_P2,
        S_P3,
        S_GAP,
        S_DONE
    } state_t;

    // The first line to be obstructed is the one on the side the object comes from.
    function automatic logic [1:0] lead_pattern(dir_t dir);
        return (dir == DIR_ENTER) ? SENS_A : SENS_B;
    endfunction

    function automatic logic [1:0] trail_pattern(dir_t dir);
        return (dir == DIR_ENTER) ? SENS_B : SENS_A;
    endfunction

endpackage

// File: rtl/car_sensor_emulator_if.sv
// Start handshake and emulated sensor lines between a stimulus controller
// (master) and the sensor emulator (slave).
interface car_sensor_emulator_if;
    logic start;
    logic dir;
    logic kind;
    logic ready;
    logic done;
    logic a;
    logic b;

    modport master (output start, output dir, output kind,
                    input ready, input done, input a, input b);
    modport slave  (input start, input dir, input kind,
                    output ready, output done, output a, output b);
endinterface

// File: rtl/car_sensor_emulator_phase_timer.sv
// Per-state cycle counter: restarts at zero on load and flags the last cycle
// of a window of limit_i cycles.
module phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == (limit_i - WIDTH'(1)));

endmodule

// File: rtl/car_sensor_emulator.sv
// Drives the a/b photo-sensor lines with the timed pattern of a car or
// pedestrian crossing in the requested direction, one crossing per start.
module car_sensor_emulator
    import car_sensor_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    car_sensor_emulator_if.slave bus
);

    localparam int MAX_CYCLES = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    state_t         state_q, state_d;
    dir_t           dir_q, dir_d;
    kind_t          kind_q, kind_d;
    logic           ready;
    logic           accept;
    logic           timer_load;
    logic           timer_en;
    logic           timer_expire;
    logic [CW-1:0]  timer_limit;
    logic [1:0]     sens;

    assign ready       = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept      = bus.start && ready;
    assign timer_en    = (state_q == S_P1) || (state_q == S_P2) ||
                         (state_q == S_P3) || (state_q == S_GAP);
    assign timer_limit = (state_q == S_GAP) ? CW'(GAP_CYCLES) : CW'(PHASE_CYCLES);
    assign timer_load  = (state_d != state_q);

    phase_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (timer_load),
        .en_i     (timer_en),
        .limit_i  (timer_limit),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        kind_d  = kind_q;
        if (accept) begin
            dir_d  = dir_t'(bus.dir);
            kind_d = kind_t'(bus.kind);
        end
        case (state_q)
            S_IDLE, S_DONE: state_d = accept ? S_P1 : S_IDLE;
            S_P1: if (timer_expire) state_d = (kind_q == KIND_PED) ? S_GAP : S_P2;
            S_P2: if (timer_expire) state_d = S_P3;
            S_P3: if (timer_expire) state_d = S_GAP;
            S_GAP: if (timer_expire) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_ENTER;
            kind_q  <= KIND_CAR;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            kind_q  <= kind_d;
        end
    end

    // Lines decode from registered state only, so reset clears them immediately.
    always_comb begin
        sens = SENS_NONE;
        case (state_q)
            S_P1:    sens = lead_pattern(dir_q);
            S_P2:    sens = SENS_AB;
            S_P3:    sens = trail_pattern(dir_q);
            default: sens = SENS_NONE;
        endcase
    end

    assign bus.a     = sens[1];
    assign bus.b     = sens[0];
    assign bus.ready = ready;
    assign bus.done  = (state_q == S_DONE);

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Scoreboard bench for car_sensor_emulator: predicts every output cycle from
// accepted starts and cross-checks the line waveform with a tiny detector model.
module tb_car_sensor_emulator;
    import car_sensor_pkg::*;

    localparam int PHASE = 4;
    localparam int GAP   = 2;

    logic clk;
    logic reset_n;
    car_sensor_emulator_if bus();

    car_sensor_emulator #(.PHASE_CYCLES(PHASE), .GAP_CYCLES(GAP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int accepts     = 0;
    int done_cnt    = 0;
    int det_enter   = 0;
    int det_exit    = 0;
    int hl          = 0;
    logic [1:0] hist [3];
    logic [3:0] sb [$];
    logic last_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {a,b,ready,done} for every cycle of one crossing.
    function automatic void push_crossing(logic d, logic k);
        logic [1:0] lead;
        logic [1:0] trail;
        lead  = d ? 2'b01 : 2'b10;
        trail = d ? 2'b10 : 2'b01;
        for (int i = 0; i < PHASE; i++) sb.push_back({lead, 2'b00});
        if (!k) begin
            for (int i = 0; i < PHASE; i++) sb.push_back(4'b1100);
            for (int i = 0; i < PHASE; i++) sb.push_back({trail, 2'b00});
        end
        for (int i = 0; i < GAP; i++) sb.push_back(4'b0000);
        sb.push_back(4'b0011);
    endfunction

    always @(posedge clk) begin
        if (reset_n === 1'b1 && bus.start === 1'b1 && last_ready) begin
            push_crossing(bus.dir, bus.kind);
            accepts++;
        end
    end

    always @(negedge reset_n) begin
        sb.delete();
        last_ready = 1'b1;
        hl = 0;
    end

    always @(negedge clk) begin : monitor
        logic [3:0] exp_v;
        logic [3:0] got_v;
        logic [1:0] ab;
        if (reset_n === 1'b1) begin
            exp_v = (sb.size() > 0) ? sb.pop_front() : 4'b0010;
            got_v = {bus.a, bus.b, bus.ready, bus.done};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL cycle_out: {a,b,ready,done} got %b expected %b at %0t", got_v, exp_v, $time);
            end
            last_ready = exp_v[1];
            if (bus.done === 1'b1) done_cnt++;
            ab = {bus.a, bus.b};
            if (ab == 2'b00) begin
                if (hl == 3 && hist[0] == 2'b10 && hist[1] == 2'b11 && hist[2] == 2'b01) det_enter++;
                else if (hl == 3 && hist[0] == 2'b01 && hist[1] == 2'b11 && hist[2] == 2'b10) det_exit++;
                hl = 0;
            end else if (hl == 0 || (hl <= 3 && hist[hl-1] != ab)) begin
                if (hl < 3) hist[hl] = ab;
                hl++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_crossing(input logic d, input logic k,
                               output int busy, output int dones, output bit got);
        busy = 0;
        dones = 0;
        got = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dir = d; bus.kind = k;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.dir = ~d; bus.kind = ~k;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); #1;
            if (!bus.ready) busy++;
            if (bus.done) begin
                dones++;
                got = 1'b1;
            end
        end
        repeat (4) begin
            @(negedge clk); #1;
            if (bus.done) dones++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dir = 1'b0; bus.kind = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.a, bus.b, bus.ready, bus.done} !== 4'b0010) begin
            miscompares++;
            $display("FAIL reset_async: {a,b,ready,done} got %b expected 0010", {bus.a, bus.b, bus.ready, bus.done});
        end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_crossing(input string name, input logic d, input logic k,
                                  input int exp_busy, input int exp_en, input int exp_ex);
        int busy, dones, e0, x0;
        bit got;
        e0 = det_enter;
        x0 = det_exit;
        do_crossing(d, k, busy, dones, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s_timeout: done never seen, expected within 40 cycles", name);
        end
        vectors++;
        if (busy !== exp_busy) begin
            miscompares++;
            $display("FAIL %s_busy: got %0d cycles expected %0d", name, busy, exp_busy);
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL %s_done: got %0d pulses expected 1", name, dones);
        end
        vectors++;
        if ((det_enter - e0) !== exp_en || (det_exit - x0) !== exp_ex) begin
            miscompares++;
            $display("FAIL %s_detector: enter/exit got %0d/%0d expected %0d/%0d",
                     name, det_enter - e0, det_exit - x0, exp_en, exp_ex);
        end
    endtask

    task automatic test_car_enter();
        check_crossing("car_enter", 1'b0, 1'b0, 3*PHASE+GAP, 1, 0);
    endtask

    task automatic test_car_exit();
        check_crossing("car_exit", 1'b1, 1'b0, 3*PHASE+GAP, 0, 1);
    endtask

    task automatic test_ped_enter();
        check_crossing("ped_enter", 1'b0, 1'b1, PHASE+GAP, 0, 0);
    endtask

    task automatic test_back_to_back();
        int a0, d0, e0, x0;
        a0 = accepts; d0 = done_cnt; e0 = det_enter; x0 = det_exit;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dir = 1'b0; bus.kind = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            bus.dir = ~bus.dir;
        end
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        vectors++;
        if ((done_cnt - d0) !== 2 || (accepts - a0) !== 2) begin
            miscompares++;
            $display("FAIL b2b_count: done pulses %0d accepts %0d expected 2/2", done_cnt - d0, accepts - a0);
        end
        vectors++;
        if ((det_enter - e0) !== 1 || (det_exit - x0) !== 1) begin
            miscompares++;
            $display("FAIL b2b_dir: enter/exit got %0d/%0d expected 1/1", det_enter - e0, det_exit - x0);
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_drain: %0d predicted cycles left expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int d0;
        seen = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dir = 1'b0; bus.kind = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.a && bus.b) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL midreset_p2: {a,b}=11 never seen, expected within 20 cycles");
        end
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.a, bus.b, bus.ready, bus.done} !== 4'b0010) begin
            miscompares++;
            $display("FAIL midreset_async: {a,b,ready,done} got %b expected 0010", {bus.a, bus.b, bus.ready, bus.done});
        end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (done_cnt !== d0 || bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_nodone: done pulses %0d ready %b expected 0/1", done_cnt - d0, bus.ready);
        end
        check_crossing("post_reset_ped_exit", 1'b1, 1'b1, PHASE+GAP, 0, 0);
    endtask

    initial begin
        reset_n = 1'b1;
        test_reset();
        test_car_enter();
        test_car_exit();
        test_ped_enter();
        test_back_to_back();
        test_reset_mid();
        test_car_enter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
